// File: rtl/inst_cache_pkg.sv
// Shared types and address-split helpers for the direct-mapped instruction cache.
package inst_cache_pkg;

    typedef enum logic {
        IC_IDLE,
        IC_FILL
    } ic_state_t;

    localparam logic [31:0] IC_INVALID_INST = 32'h0;

    // Word-select bits within a line.
    function automatic int unsigned ic_offset_bits(input int unsigned words_per_line);
        return $clog2(words_per_line);
    endfunction

    // Line-select bits.
    function automatic int unsigned ic_index_bits(input int unsigned lines);
        return $clog2(lines);
    endfunction

    // Everything above offset, index and the two byte bits.
    function automatic int unsigned ic_tag_bits(input int unsigned lines,
                                                input int unsigned words_per_line);
        return 30 - ic_offset_bits(words_per_line) - ic_index_bits(lines);
    endfunction

endpackage

// File: rtl/inst_cache_array.sv
// Valid/tag/data storage: combinational read, one-word write, flush-all and reset of valid bits.
module inst_cache_array
    import inst_cache_pkg::*;
#(
    parameter int unsigned LINES          = 8,
    parameter int unsigned WORDS_PER_LINE = 4
) (
    input  logic                                         clk,
    input  logic                                         rst_b,
    input  logic                                         flush_all,
    input  logic [ic_index_bits(LINES)-1:0]              rd_index,
    input  logic [ic_offset_bits(WORDS_PER_LINE)-1:0]    rd_offset,
    output logic                                         rd_valid,
    output logic [ic_tag_bits(LINES, WORDS_PER_LINE)-1:0] rd_tag,
    output logic [31:0]                                  rd_word,
    input  logic                                         wr_en,
    input  logic [ic_index_bits(LINES)-1:0]              wr_index,
    input  logic [ic_offset_bits(WORDS_PER_LINE)-1:0]    wr_offset,
    input  logic [31:0]                                  wr_data,
    input  logic                                         set_valid,
    input  logic [ic_tag_bits(LINES, WORDS_PER_LINE)-1:0] set_tag
);

    localparam int unsigned TAG_W = ic_tag_bits(LINES, WORDS_PER_LINE);

    logic [LINES-1:0] valid_q;
    logic [TAG_W-1:0] tag_q  [LINES];
    logic [31:0]      data_q [LINES][WORDS_PER_LINE];

    // Valid bits: reset and flush clear every line; a completed fill marks one line valid.
    always_ff @(posedge clk) begin
        if (!rst_b || flush_all) begin
            valid_q <= '0;
        end else if (set_valid) begin
            valid_q[wr_index] <= 1'b1;
        end
    end

    // Tag and data storage; never reset, only meaningful behind a set valid bit.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            data_q[wr_index][wr_offset] <= wr_data;
        end
        if (set_valid) begin
            tag_q[wr_index] <= set_tag;
        end
    end

    assign rd_valid = valid_q[rd_index];
    assign rd_tag   = tag_q[rd_index];
    assign rd_word  = data_q[rd_index][rd_offset];

endmodule

// File: rtl/inst_cache.sv
// Direct-mapped read-only instruction cache; stalls fetch and fills a line word by word on a miss.
module inst_cache
    import inst_cache_pkg::*;
#(
    parameter int unsigned LINES          = 8,
    parameter int unsigned WORDS_PER_LINE = 4
) (
    input  logic        clk,
    input  logic        rst_b,
    input  logic [31:0] inst_addr,
    output logic [31:0] inst,
    output logic        inst_valid,
    input  logic        flush,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);

    localparam int unsigned OFF_W  = ic_offset_bits(WORDS_PER_LINE);
    localparam int unsigned IDX_W  = ic_index_bits(LINES);
    localparam int unsigned TAG_W  = ic_tag_bits(LINES, WORDS_PER_LINE);
    localparam int unsigned LINE_W = IDX_W + TAG_W;

    ic_state_t         state_q, state_d;
    logic [LINE_W-1:0] line_q, line_d;
    logic [OFF_W-1:0]  cnt_q, cnt_d;
    logic              pend_q, pend_d;

    logic              rd_valid;
    logic [TAG_W-1:0]  rd_tag;
    logic [31:0]       rd_word;
    logic              hit;
    logic              wr_en;
    logic              set_valid;
    logic              unused_byte_bits;

    assign unused_byte_bits = ^inst_addr[1:0];

    inst_cache_array #(
        .LINES          (LINES),
        .WORDS_PER_LINE (WORDS_PER_LINE)
    ) u_array (
        .clk       (clk),
        .rst_b     (rst_b),
        .flush_all (flush),
        .rd_index  (inst_addr[OFF_W+2 +: IDX_W]),
        .rd_offset (inst_addr[2 +: OFF_W]),
        .rd_valid  (rd_valid),
        .rd_tag    (rd_tag),
        .rd_word   (rd_word),
        .wr_en     (wr_en),
        .wr_index  (line_q[IDX_W-1:0]),
        .wr_offset (cnt_q),
        .wr_data   (mem_rdata),
        .set_valid (set_valid),
        .set_tag   (line_q[LINE_W-1:IDX_W])
    );

    assign hit = rd_valid && (rd_tag == inst_addr[31 -: TAG_W]);

    // State register; the captured line address is plain data and is not reset.
    always_ff @(posedge clk) begin
        if (!rst_b) begin
            state_q <= IC_IDLE;
            cnt_q   <= '0;
            pend_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
        end
        line_q <= line_d;
    end

    // Next state and outputs: serve hits in IDLE, walk the line's words in FILL.
    always_comb begin
        state_d    = state_q;
        line_d     = line_q;
        cnt_d      = cnt_q;
        pend_d     = pend_q;
        wr_en      = 1'b0;
        set_valid  = 1'b0;
        inst_valid = 1'b0;
        mem_req    = 1'b0;
        unique case (state_q)
            IC_IDLE: begin
                inst_valid = hit && !flush;
                if (!hit) begin
                    state_d = IC_FILL;
                    line_d  = inst_addr[31:OFF_W+2];
                    cnt_d   = '0;
                end
            end
            IC_FILL: begin
                mem_req = 1'b1;
                if (mem_ack) begin
                    wr_en = 1'b1;
                    cnt_d = cnt_q + 1'b1;
                end
                // A flush on the final ack still leaves the line invalid.
                if (mem_ack && (cnt_q == '1)) begin
                    set_valid = !pend_q && !flush;
                    pend_d    = 1'b0;
                    state_d   = IC_IDLE;
                end else if (flush) begin
                    pend_d = 1'b1;
                end
            end
            default: state_d = IC_IDLE;
        endcase
    end

    assign inst     = inst_valid ? rd_word : IC_INVALID_INST;
    assign mem_addr = mem_req ? {line_q, cnt_q, 2'b00} : '0;

endmodule

// File: tb/tb_inst_cache.sv
// Randomized and directed checking of inst_cache against a line-level behavioural model.
module tb_inst_cache;

    localparam int unsigned LINES      = 8;
    localparam int unsigned WPL        = 4;
    localparam int unsigned LINE_BYTES = WPL * 4;

    logic        clk = 1'b0;
    logic        rst_b;
    logic [31:0] inst_addr;
    logic [31:0] inst;
    logic        inst_valid;
    logic        flush;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    inst_cache #(
        .LINES          (LINES),
        .WORDS_PER_LINE (WPL)
    ) dut (
        .clk        (clk),
        .rst_b      (rst_b),
        .inst_addr  (inst_addr),
        .inst       (inst),
        .inst_valid (inst_valid),
        .flush      (flush),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_ack    (mem_ack),
        .mem_rdata  (mem_rdata)
    );

    always #5 clk = ~clk;

    int unsigned n_vec;
    int unsigned n_err;

    // Model: which line base address each slot holds, plus the fill in flight.
    bit          m_fill;
    bit          m_pend;
    logic [31:0] m_base;
    int unsigned m_cnt;
    bit          m_valid [LINES];
    logic [31:0] m_line  [LINES];

    // Outputs as sampled in the most recent step, for literal checks.
    logic        s_valid;
    logic [31:0] s_inst;
    logic        s_req;
    logic [31:0] s_addr;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return 32'h1000 + a;
    endfunction

    function automatic logic [31:0] line_of(input logic [31:0] a);
        return a & ~32'(LINE_BYTES - 1);
    endfunction

    function automatic int unsigned idx_of(input logic [31:0] a);
        return (a / LINE_BYTES) % LINES;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    task automatic model_clear_valid();
        for (int i = 0; i < LINES; i++) m_valid[i] = 1'b0;
    endtask

    // One clock: drive at negedge, compare 1ns later, advance the model at the posedge.
    task automatic step(input logic [31:0] a, input logic f, input logic ack, input logic rb);
        logic        hit;
        logic [31:0] exp_addr;
        int unsigned ix;
        exp_addr  = m_fill ? (m_base + 32'(4 * m_cnt)) : 32'h0;
        inst_addr = a;
        flush     = f;
        mem_ack   = ack;
        rst_b     = rb;
        mem_rdata = (ack && m_fill) ? mem_word(exp_addr) : $urandom();
        #1;
        ix  = idx_of(a);
        hit = !m_fill && m_valid[ix] && (m_line[ix] == line_of(a));
        s_valid = inst_valid;
        s_inst  = inst;
        s_req   = mem_req;
        s_addr  = mem_addr;
        chk("inst_valid", 32'(inst_valid), 32'(hit && !f));
        chk("inst", inst, (hit && !f) ? mem_word(a & ~32'h3) : 32'h0);
        chk("mem_req", 32'(mem_req), 32'(m_fill));
        chk("mem_addr", mem_addr, exp_addr);
        @(posedge clk);
        if (!rb) begin
            m_fill = 1'b0;
            m_pend = 1'b0;
            m_cnt  = 0;
            model_clear_valid();
        end else if (!m_fill) begin
            if (f) model_clear_valid();
            if (!hit) begin
                m_fill = 1'b1;
                m_base = line_of(a);
                m_cnt  = 0;
            end
        end else begin
            if (f) model_clear_valid();
            if (ack) m_cnt++;
            if (ack && m_cnt == WPL) begin
                m_fill = 1'b0;
                if (!m_pend && !f) begin
                    m_valid[idx_of(m_base)] = 1'b1;
                    m_line[idx_of(m_base)]  = m_base;
                end
                m_pend = 1'b0;
            end else if (f) begin
                m_pend = 1'b1;
            end
        end
        @(negedge clk);
    endtask

    // Serve every word of the current fill, with `gap` idle cycles before each ack.
    task automatic serve(input logic [31:0] a, input int unsigned gap);
        for (int w = 0; w < WPL; w++) begin
            repeat (gap) step(a, 1'b0, 1'b0, 1'b1);
            step(a, 1'b0, 1'b1, 1'b1);
        end
    endtask

    logic [31:0] ra;

    initial begin
        n_vec = 0;
        n_err = 0;
        m_fill = 1'b0;
        m_pend = 1'b0;
        m_cnt  = 0;
        m_base = '0;
        model_clear_valid();
        for (int i = 0; i < LINES; i++) m_line[i] = '0;
        inst_addr = 32'h0;
        flush     = 1'b0;
        mem_ack   = 1'b0;
        mem_rdata = 32'h0;
        rst_b     = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);

        // Reset state
        step(32'h40, 1'b0, 1'b0, 1'b0);
        chk("rst_req", 32'(s_req), 32'h0);
        chk("rst_addr", s_addr, 32'h0);
        chk("rst_valid", 32'(s_valid), 32'h0);
        chk("rst_inst", s_inst, 32'h0);

        // Cold miss of 0x40 with single-cycle acks
        step(32'h40, 1'b0, 1'b0, 1'b1);
        chk("cold_miss", 32'(s_valid), 32'h0);
        for (int k = 0; k < WPL; k++) begin
            step(32'h40, 1'b0, 1'b1, 1'b1);
            chk("cold_req", 32'(s_req), 32'h1);
            chk("cold_addr", s_addr, 32'h40 + 32'(4 * k));
        end
        step(32'h40, 1'b0, 1'b0, 1'b1);
        chk("cold_hit", 32'(s_valid), 32'h1);
        chk("cold_inst", s_inst, 32'h1040);
        for (int k = 1; k < WPL; k++) begin
            step(32'h40 + 32'(4 * k), 1'b0, 1'b0, 1'b1);
            chk("cold_word_inst", s_inst, 32'h1040 + 32'(4 * k));
        end

        // Conflict eviction: 0xC0 shares index 4 with 0x40
        step(32'hC0, 1'b0, 1'b0, 1'b1);
        chk("conflict_miss", 32'(s_valid), 32'h0);
        serve(32'hC0, 0);
        step(32'hC0, 1'b0, 1'b0, 1'b1);
        chk("conflict_inst", s_inst, 32'h10C0);
        step(32'h40, 1'b0, 1'b0, 1'b1);
        chk("evicted_miss", 32'(s_valid), 32'h0);

        // Slow memory refill of 0x40: each word held 3 cycles
        for (int w = 0; w < WPL; w++) begin
            for (int c = 0; c < 3; c++) begin
                step(32'h40, 1'b0, c == 2, 1'b1);
                chk("slow_req", 32'(s_req), 32'h1);
                chk("slow_addr", s_addr, 32'h40 + 32'(4 * w));
            end
        end
        step(32'h40, 1'b0, 1'b0, 1'b1);
        chk("slow_hit", 32'(s_valid), 32'h1);

        // Flush in IDLE, then address change during the second word
        step(32'h40, 1'b1, 1'b0, 1'b1);
        chk("flush_idle_valid", 32'(s_valid), 32'h0);
        step(32'h40, 1'b0, 1'b0, 1'b1);
        chk("flush_idle_miss", 32'(s_valid), 32'h0);
        step(32'h40, 1'b0, 1'b1, 1'b1);
        step(32'h80, 1'b0, 1'b1, 1'b1);
        chk("midfill_addr", s_addr, 32'h44);
        step(32'h80, 1'b0, 1'b1, 1'b1);
        step(32'h80, 1'b0, 1'b1, 1'b1);
        step(32'h80, 1'b0, 1'b0, 1'b1);
        chk("midfill_new_miss", 32'(s_valid), 32'h0);
        serve(32'h80, 0);
        step(32'h80, 1'b0, 1'b0, 1'b1);
        chk("midfill_new_hit", s_inst, 32'h1080);
        step(32'h40, 1'b0, 1'b0, 1'b1);
        chk("midfill_old_hit", 32'(s_valid), 32'h1);

        // Flush during fill leaves the line invalid
        step(32'h40, 1'b1, 1'b0, 1'b1);
        step(32'h40, 1'b0, 1'b0, 1'b1);
        step(32'h40, 1'b0, 1'b1, 1'b1);
        step(32'h40, 1'b1, 1'b0, 1'b1);
        serve(32'h40, 0);
        step(32'h40, 1'b0, 1'b0, 1'b1);
        chk("flush_fill_miss", 32'(s_valid), 32'h0);
        step(32'h40, 1'b0, 1'b0, 1'b1);
        chk("flush_fill_refetch", s_addr, 32'h40);
        serve(32'h40, 0);
        step(32'h40, 1'b0, 1'b0, 1'b1);
        chk("flush_fill_hit", 32'(s_valid), 32'h1);

        // Reset mid-fill after two acks, then a stray ack
        step(32'h40, 1'b1, 1'b0, 1'b1);
        step(32'h40, 1'b0, 1'b0, 1'b1);
        step(32'h40, 1'b0, 1'b1, 1'b1);
        step(32'h40, 1'b0, 1'b1, 1'b1);
        step(32'h40, 1'b0, 1'b0, 1'b0);
        step(32'h40, 1'b0, 1'b1, 1'b1);
        chk("rst_fill_req", 32'(s_req), 32'h0);
        chk("rst_fill_miss", 32'(s_valid), 32'h0);
        step(32'h40, 1'b0, 1'b0, 1'b1);
        chk("rst_fill_restart", s_addr, 32'h40);
        serve(32'h40, 0);
        step(32'h40, 1'b0, 1'b0, 1'b1);
        chk("rst_fill_hit", s_inst, 32'h1040);

        // Random traffic: sticky addresses for hits, random acks, rare flush/reset
        ra = 32'h40;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 99) < 30) begin
                ra = 32'($urandom_range(0, 255)) * 4;
                if ($urandom_range(0, 9) == 0) ra[31:28] = 4'($urandom());
            end
            step(ra, $urandom_range(0, 99) < 3, $urandom_range(0, 99) < 55,
                 $urandom_range(0, 199) != 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/inst_cache.md
# inst_cache

Direct-mapped, read-only instruction cache that acts as the responder to the fetch stage's instruction-address port. The fetch stage drives `inst_addr` and consumes `inst`; `inst_valid` gates its `pc_enable`. On a miss the cache stalls fetch and fills one line from a slower backing instruction memory through a req/ack word handshake. It sits between the fetch stage and the instruction memory model.

## Interface
Parameters:
- `LINES`, 8: number of cache lines; power of two, ≥2.
- `WORDS_PER_LINE`, 4: 32-bit words per line; power of two, ≥2.

Ports:
- `clk`  in  1  the single clock; all state changes on its rising edge.
- `rst_b`  in  1  reset, synchronous and active-low.
- `inst_addr`  in  32  fetch byte address; bits [1:0] ignored.
- `inst`  out  32  instruction word; 32'h0 when `inst_valid`=0.
- `inst_valid`  out  1  `inst` is valid for `inst_addr` this cycle; drives fetch `pc_enable`.
- `flush`  in  1  invalidate all lines.
- `mem_req`  out  1  word read request to backing memory.
- `mem_addr`  out  32  word-aligned byte address of the requested word.
- `mem_ack`  in  1  `mem_rdata` valid; completes the current request.
- `mem_rdata`  in  32  returned word.

## Operation
- Address split: offset = `inst_addr[1+log2(WORDS_PER_LINE):2]`, index = next `log2(LINES)` bits, tag = remaining upper bits.
- Storage: per line a valid bit, a tag, and `WORDS_PER_LINE` words.
- States: IDLE, FILL.
- IDLE: hit = valid[index] && tag match. On hit, `inst_valid`=1 and `inst` = the stored word, both combinational. On miss, `inst_valid`=0; capture the line base address (`inst_addr` with offset and byte bits cleared), clear the word counter, go to FILL.
- FILL: `mem_req`=1 and `mem_addr` = base + 4·counter; both hold stable until `mem_ack`.
  - On `mem_ack`: write `mem_rdata` into word[counter] of the captured line and increment the counter.
  - On the ack of the last word: set valid and tag for the line (unless a flush is pending), clear the pending flag, go to IDLE.
  - `inst_valid`=0 throughout FILL.
- `inst_addr` changes during FILL are ignored. The fill completes for the captured line, and IDLE then re-evaluates the current address.
- `flush` in IDLE: all valid bits clear at the edge; `inst_valid`=0 in the cycle `flush` is high.
- `flush` in FILL: all valid bits clear and a pending flag is set. The line in flight is written but left invalid.
- Reset (`rst_b`=0 at an edge): state IDLE, all valid bits 0, counter 0, pending flag 0. Data and tag arrays are not reset. This holds mid-fill; a later ack for the abandoned request is ignored in IDLE.
- Reset output values: `inst_valid`=0, `inst`=0, `mem_req`=0, `mem_addr`=0.
- `mem_ack` while `mem_req`=0 is ignored.

## Timing
- Hit latency: 0 cycles (combinational from `inst_addr`).
- Miss detection: edge N moves the cache to FILL; `mem_req` is high from cycle N+1.
- Each word takes ≥1 cycle. With single-cycle ack the miss penalty is 1 + `WORDS_PER_LINE` cycles. At the edge of the final ack the line becomes valid, and the following cycle is a hit if `inst_addr` is unchanged.
- Back-to-back requests: after an ack, `mem_addr` advances on the same edge and `mem_req` stays high.

## Structure
- `inst_cache_pkg` holds:
  - state enum `ic_state_t` {IC_IDLE, IC_FILL};
  - width functions/localparams for offset, index and tag;
  - `IC_INVALID_INST` = 32'h0.
- One sub-module, `inst_cache_array`: valid/tag/data storage with combinational read and single-word write port, plus flush-all and reset-valid inputs. The controller FSM stays in `inst_cache`.

## Test plan
Defaults: LINES=8, WORDS_PER_LINE=4.
- Cold miss: after reset, `inst_addr`=0x40, memory acks every cycle returning 0x1000+addr. Required:
  - `mem_addr` = 0x40, 0x44, 0x48, 0x4C on consecutive cycles;
  - `inst_valid`=1 with `inst`=0x1040 on cycle 6;
  - then 0x44..0x4C hit in 0 cycles.
- Conflict eviction: fill 0x40, then fetch 0xC0 (same index 4, tag 1) → miss and fill of 0xC0–0xCC; re-fetching 0x40 then misses again.
- Slow memory: ack delayed 3 cycles per word → `mem_req` and `mem_addr` hold stable for 3 cycles each; `inst_valid` rises 1 cycle after the 4th ack.
- Address change mid-fill: `inst_addr` moves 0x40→0x80 during the second word → fill of 0x40 line completes, then 0x80 miss starts; 0x40 later hits.
- Flush: flush in IDLE after fill of 0x40 → next fetch of 0x40 misses. Flush during fill of 0x40 → line not marked valid, refetch issued.
- Reset mid-fill: `rst_b`=0 after 2 acks → `mem_req`=0 next cycle; a stray ack is ignored; 0x40 misses afterwards.
